// File: rtl/nonce_dispatcher_pkg.sv
// Shared types and widths for the nonce dispatcher slice (package bcx_pkg).
package bcx_pkg;

  localparam int unsigned STATE_W = 352;
  localparam int unsigned NONCE_W = 32;
  localparam int unsigned SUM_W   = NONCE_W + 1;
  localparam int unsigned JOB_COUNT_W = 48;
  localparam int unsigned PREEMPT_W   = 16;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [NONCE_W-1:0] nonce_t;

  typedef enum logic [1:0] {
    DSP_IDLE,
    DSP_RUN,
    DSP_EXHAUSTED
  } dispatch_state_e;

  typedef struct packed {
    state_t state;
    nonce_t nonce;
  } job_payload_t;

endpackage

// File: rtl/nonce_dispatcher_if.sv
// Block-storage input and hash-job output bundle of nonce_dispatcher.
// Optional statistics signals exist only with NONCE_DISPATCH_STATS_EN.
interface nonce_dispatcher_if
  import bcx_pkg::*;
#(
  parameter int unsigned EPOCH_W = 4
);

  logic               inputValid;
  logic               newBlock;
  state_t             initialState;
  logic               jobValid;
  state_t             jobState;
  nonce_t             jobNonce;
  logic [EPOCH_W-1:0] jobEpoch;
  logic               exhausted;
`ifdef NONCE_DISPATCH_STATS_EN
  logic [JOB_COUNT_W-1:0] jobCount;
  logic [PREEMPT_W-1:0]   preempted;

  modport slave (
    input  inputValid, newBlock, initialState,
    output jobValid, jobState, jobNonce, jobEpoch, exhausted, jobCount, preempted
  );

  modport master (
    output inputValid, newBlock, initialState,
    input  jobValid, jobState, jobNonce, jobEpoch, exhausted, jobCount, preempted
  );
`else
  modport slave (
    input  inputValid, newBlock, initialState,
    output jobValid, jobState, jobNonce, jobEpoch, exhausted
  );

  modport master (
    output inputValid, newBlock, initialState,
    input  jobValid, jobState, jobNonce, jobEpoch, exhausted
  );
`endif

endinterface

// File: rtl/nonce_dispatcher_counter.sv
// Per-block nonce walk: holds the next nonce and flags when the issued nonce is the last one.
module nonce_counter
  import bcx_pkg::*;
#(
  parameter nonce_t NONCE_BASE   = '0,
  parameter nonce_t NONCE_STRIDE = NONCE_W'(1)
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   step,
  output nonce_t issue_nonce_c,
  output logic   carry_c
);

  nonce_t           next_q;
  logic [SUM_W-1:0] sum_c;

  // A load issues the base nonce regardless of where the previous walk stood.
  always_comb begin
    issue_nonce_c = load ? NONCE_BASE : next_q;
    sum_c         = {1'b0, issue_nonce_c} + {1'b0, NONCE_STRIDE};
    carry_c       = sum_c[NONCE_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_q <= NONCE_BASE;
    end else if (load || step) begin
      next_q <= sum_c[NONCE_W-1:0];
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Turns held block headers into a one-job-per-cycle stream of {state, nonce, epoch}.
// Define NONCE_DISPATCH_STATS_EN to add the jobCount/preempted statistics outputs.
module nonce_dispatcher
  import bcx_pkg::*;
#(
  parameter nonce_t      NONCE_BASE   = '0,
  parameter nonce_t      NONCE_STRIDE = NONCE_W'(1),
  parameter int unsigned EPOCH_W      = 4
) (
  input logic               clk,
  input logic               rst,
  nonce_dispatcher_if.slave bus
);

  dispatch_state_e    state_q, state_d;
  logic               accept_new_c;
  logic               step_c;
  logic               issue_c;
  logic               exhausted_d;
  nonce_t             issue_nonce_c;
  logic               carry_c;

  logic               job_valid_q;
  job_payload_t       job_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               exhausted_q;

  assign accept_new_c = bus.inputValid & bus.newBlock;
  assign issue_c      = accept_new_c | step_c;

  nonce_counter #(
    .NONCE_BASE   (NONCE_BASE),
    .NONCE_STRIDE (NONCE_STRIDE)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .load          (accept_new_c),
    .step          (step_c),
    .issue_nonce_c (issue_nonce_c),
    .carry_c       (carry_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DSP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A fresh block always wins; otherwise only RUN issues, and a carry ends the walk.
  always_comb begin
    state_d     = state_q;
    step_c      = 1'b0;
    exhausted_d = 1'b0;
    if (accept_new_c) begin
      state_d = carry_c ? DSP_EXHAUSTED : DSP_RUN;
    end else begin
      unique case (state_q)
        DSP_RUN: begin
          if (bus.inputValid) begin
            step_c  = 1'b1;
            state_d = carry_c ? DSP_EXHAUSTED : DSP_RUN;
          end else begin
            state_d = DSP_IDLE;
          end
        end
        DSP_EXHAUSTED: exhausted_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Job fields hold between issues so the consumer sees the last job until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_valid_q <= 1'b0;
      job_q       <= '0;
      epoch_q     <= '0;
      exhausted_q <= 1'b0;
    end else begin
      job_valid_q <= issue_c;
      exhausted_q <= exhausted_d;
      if (issue_c) begin
        job_q.state <= bus.initialState;
        job_q.nonce <= issue_nonce_c;
      end
      if (accept_new_c) begin
        epoch_q <= epoch_q + EPOCH_W'(1);
      end
    end
  end

  assign bus.jobValid  = job_valid_q;
  assign bus.jobState  = job_q.state;
  assign bus.jobNonce  = job_q.nonce;
  assign bus.jobEpoch  = epoch_q;
  assign bus.exhausted = exhausted_q;

`ifdef NONCE_DISPATCH_STATS_EN
  logic [JOB_COUNT_W-1:0] job_count_q;
  logic [PREEMPT_W-1:0]   preempted_q;

  // Saturating counters; a preemption is a new block arriving while a walk is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_count_q <= '0;
      preempted_q <= '0;
    end else begin
      if (issue_c && (job_count_q != '1)) begin
        job_count_q <= job_count_q + JOB_COUNT_W'(1);
      end
      if (accept_new_c && (state_q == DSP_RUN) && (preempted_q != '1)) begin
        preempted_q <= preempted_q + PREEMPT_W'(1);
      end
    end
  end

  assign bus.jobCount  = job_count_q;
  assign bus.preempted = preempted_q;
`endif

endmodule
